// File: rtl/serial_code_pkg.sv
// Shared types and defaults for the serial word framers.
package serial_code_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SHIFT,
    PH_LAST
  } frame_phase_t;

  localparam int unsigned DEF_WORD_W   = 4;
  localparam int unsigned DEF_MAX_CODE = 9;

  // Parity bit that brings the word's ones-count to the requested sense.
  function automatic logic parity_bit(input logic ones_odd, input parity_mode_t mode);
    return ones_odd ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for serial word framing; advances once per accepted bit
// and wraps after WORD_W bits.
module serial_bit_counter
  import serial_code_pkg::*;
#(
  parameter  int unsigned WORD_W = DEF_WORD_W,
  localparam int unsigned CNT_W  = $clog2(WORD_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             first,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  frame_phase_t     phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    if (cnt_q == '0) begin
      phase = PH_IDLE;
    end else if (cnt_q == CNT_LAST) begin
      phase = PH_LAST;
    end else begin
      phase = PH_SHIFT;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      case (phase)
        PH_LAST: cnt_d = '0;
        default: cnt_d = cnt_q + CNT_W'(1);
      endcase
    end
  end

  always_comb begin
    bit_cnt = cnt_q;
    first   = (phase == PH_IDLE);
    last    = (phase == PH_LAST);
  end

endmodule

// File: rtl/serial_word_parity_gen.sv
// Frames a qualified MSB-first serial stream into WORD_W-bit words and emits a
// per-word odd/even parity bit. Define WORD_RANGE_CHECK_EN to flag words > MAX_CODE.
module serial_word_parity_gen
  import serial_code_pkg::*;
#(
  parameter  int unsigned WORD_W   = DEF_WORD_W,
  parameter  int unsigned MAX_CODE = DEF_MAX_CODE,
  localparam int unsigned CNT_W    = $clog2(WORD_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x,
  input  logic              x_valid,
  input  logic              mode_odd,
  output logic              z,
  output logic              z_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              code_err
);

  logic [CNT_W-1:0]  cnt_unused;
  logic              first, last;
  logic [WORD_W-1:0] assembled;

  logic [WORD_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  parity_mode_t      mode_q, mode_d;
  logic              z_q, z_d;
  logic              zv_q, zv_d;
  logic [WORD_W-1:0] word_q, word_d;

  serial_bit_counter #(
    .WORD_W (WORD_W)
  ) u_bit_counter (
    .clock   (clock),
    .reset   (reset),
    .advance (x_valid),
    .bit_cnt (cnt_unused),
    .first   (first),
    .last    (last)
  );

  assign assembled = {shift_q[WORD_W-2:0], x};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      par_q   <= 1'b0;
      mode_q  <= PAR_EVEN;
      z_q     <= 1'b0;
      zv_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      shift_q <= shift_d;
      par_q   <= par_d;
      mode_q  <= mode_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      word_q  <= word_d;
    end
  end

  // The first bit reloads the accumulator, so the previous word's parity never leaks in.
  always_comb begin
    shift_d = shift_q;
    par_d   = par_q;
    mode_d  = mode_q;
    z_d     = z_q;
    zv_d    = 1'b0;
    word_d  = word_q;
    if (x_valid) begin
      shift_d = assembled;
      if (first) begin
        mode_d = parity_mode_t'(mode_odd);
        par_d  = x;
      end else begin
        par_d  = par_q ^ x;
      end
      if (last) begin
        z_d    = parity_bit(par_q ^ x, mode_q);
        word_d = assembled;
        zv_d   = 1'b1;
      end
    end
  end

`ifdef WORD_RANGE_CHECK_EN
  logic err_q, err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    err_d = err_q;
    if (x_valid && last) begin
      err_d = (32'(assembled) > MAX_CODE);
    end
  end

  assign code_err = err_q;
`else
  localparam int unsigned UNUSED_MAX_CODE = MAX_CODE;

  assign code_err = 1'b0;
`endif

  assign z        = z_q;
  assign z_valid  = zv_q;
  assign word_out = word_q;

endmodule

// File: doc/serial_word_parity_gen.md
Name: serial_word_parity_gen

Overview:
Parametrised successor to the serial BCD odd-parity generator. Accepts a serial bit stream MSB-first, frames it into WORD_W-bit words, and emits one parity bit per word. Parity mode (odd/even) is selectable at runtime. Input is gated by a qualifier so that gaps in the stream do not break framing. Sits between a serial source and the downstream framer/transmitter that appends the parity bit.

Parameters:
WORD_W, 4, bits per word; legal range 2..16.
MAX_CODE, 9, largest legal word value; used only when the range check is compiled in.
CNT_W, $clog2(WORD_W), bit-counter width; derived, not overridden.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
x  input  1  serial data bit, MSB first
x_valid  input  1  x is sampled only when 1
mode_odd  input  1  1 = odd parity, 0 = even; sampled on the first bit of each word
z  output  1  parity bit of the completed word
z_valid  output  1  one-cycle strobe; z, word_out and code_err are valid
word_out  output  WORD_W  completed word, parallel
code_err  output  1  completed word value > MAX_CODE

Behaviour:
- Reset (reset=0, asynchronous) drives all registers to 0: bit_cnt, par_acc, shift_reg, mode_lat, z, z_valid, word_out, code_err.
- Clock edge with x_valid=1 accepts one bit:
  - shift_reg <= {shift_reg[WORD_W-2:0], x}
  - par_acc <= par_acc ^ x
  - bit_cnt increments.
- When bit_cnt==0, the same edge also:
  - latches mode_lat <= mode_odd
  - loads par_acc <= x, ignoring the stale accumulator.
- mode_odd changes mid-word are ignored.
- When bit_cnt==WORD_W-1 and x_valid=1 (last bit accepted), registered outputs update on that edge:
  - z <= (par_acc ^ x) ^ mode_lat
  - word_out <= {shift_reg[WORD_W-2:0], x}
  - z_valid <= 1
  - bit_cnt wraps to 0.
- Latency: z_valid is high in the cycle immediately after the last bit is sampled, for exactly one cycle.
- Back-to-back words: the first bit of the next word can be accepted in that same cycle. Full throughput is one word per WORD_W valid cycles, with no dead cycle.
- z_valid clears to 0 on every edge with no word completion.
- z and word_out hold their last value until the next completion.
- x_valid=0: no state change except z_valid clearing. Gaps of any length are allowed mid-word.
- Reset asserted mid-word discards the partial word. The next accepted bit is bit 0 of a new word.
- Parity definition: odd mode gives total ones across word plus z as odd; even mode gives that total as even.
- FSM view: IDLE (bit_cnt=0), SHIFT (0<bit_cnt<WORD_W-1), LAST (bit_cnt=WORD_W-1). Transitions occur only on x_valid=1; LAST always returns to IDLE.

Optional Feature:
- Macro: WORD_RANGE_CHECK_EN.
- Defined: on completion, code_err <= (assembled word > MAX_CODE). code_err is valid with z_valid and holds like z. For WORD_W=4 and MAX_CODE=9, this flags the invalid BCD codes 1010..1111.
- Undefined: code_err is tied to 0, with no comparator logic, and MAX_CODE is unused.

Decomposition:
- Shared package serial_code_pkg holds:
  - typedef enum parity_mode_t {PAR_EVEN=0, PAR_ODD=1}
  - localparam defaults DEF_WORD_W=4 and DEF_MAX_CODE=9.
- One sub-module, serial_bit_counter, is natural. It is parametrised by WORD_W and takes clock, reset and advance (=x_valid). It outputs bit_cnt, first (bit_cnt==0) and last (bit_cnt==WORD_W-1). It is reusable by later serial framers.

Test Plan:
- WORD_W=4, mode_odd=1, continuous x_valid, words 0000, 0001, 0111 -> z=1, 0, 0; each z_valid is a single-cycle pulse one cycle after the 4th bit; word_out=0000, 0001, 0111.
- mode_odd=0, word 0011 then 1101 -> z=0 then z=1; flipping mode_odd at bit 2 of the second word does not change its z.
- Word 0101 with x_valid=0 for 3 cycles between bits 1 and 2 -> z=1 (odd mode), word_out=0101, z_valid pulses once only after the 4th valid bit.
- Reset pulsed low after 2 bits of 1111, then 0010 sent -> no z_valid for the partial word; next z_valid has word_out=0010, z=0 (odd mode).
- WORD_RANGE_CHECK_EN defined, BCD sweep 0000..1001 then 1010, 1111 -> code_err=0 for 0..9, code_err=1 for 1010 and 1111; undefined -> code_err always 0.
- WORD_W=8, odd mode, 0xA5 then 0xFF back-to-back -> z=1 then z=1, z_valid exactly 8 cycles apart.
